// File: rtl/thunder_tsip_pkg.sv
// Shared constants, FSM state type and field helpers for the Thunderbolt
// TSIP timing packet parser (framing bytes, field indices, range check).
package thunder_tsip_pkg;

  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ID,
    ST_DATA,
    ST_DATA_DLE,
    ST_SKIP
  } tsip_state_e;

  localparam logic [4:0] IDX_SUB   = 5'd0;
  localparam logic [4:0] IDX_SEC   = 5'd10;
  localparam logic [4:0] IDX_MIN   = 5'd11;
  localparam logic [4:0] IDX_HOUR  = 5'd12;
  localparam logic [4:0] IDX_DAY   = 5'd13;
  localparam logic [4:0] IDX_MON   = 5'd14;
  localparam logic [4:0] IDX_YR_HI = 5'd15;
  localparam logic [4:0] IDX_YR_LO = 5'd16;
  localparam logic [4:0] PKT_LEN   = 5'd17;
  localparam logic [4:0] IDX_MAX   = 5'd31;

  // Plausibility window for a UTC timestamp (60 allows a leap second).
  function automatic logic fields_in_range(
    input logic [7:0]  sec,
    input logic [7:0]  mn,
    input logic [7:0]  hr,
    input logic [7:0]  day,
    input logic [7:0]  mon,
    input logic [15:0] yr
  );
    return (sec <= 8'd60) && (mn <= 8'd59) && (hr <= 8'd23) &&
           (day != 8'd0) && (day <= 8'd31) &&
           (mon != 8'd0) && (mon <= 8'd12) &&
           (yr >= 16'd2000);
  endfunction

endpackage

// File: rtl/thunder_tsip_parser_deframer.sv
// tsip_deframer: TSIP DLE framing and destuffing state machine.
// Ports: i_clk, i_rst (sync, active high), i_rx_dv/i_rx_byte (UART bytes);
//   o_byte_dv/o_byte (destuffed data byte of an accepted-ID packet),
//   o_sop/o_id (an ID byte was taken), o_eop (DLE ETX closed an accepted
//   packet), o_abort (accepted packet cut short by DLE + new ID).
// All outputs are combinational strobes in the same cycle as the byte.
module tsip_deframer
  import thunder_tsip_pkg::*;
#(
  parameter logic [7:0] PACKET_ID = 8'h8F
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_byte_dv,
  output logic [7:0] o_byte,
  output logic       o_sop,
  output logic [7:0] o_id,
  output logic       o_eop,
  output logic       o_abort
);

  tsip_state_e state_q, state_d;
  // Inside SKIP: the previous byte was an unpaired DLE.
  logic        skip_dle_q, skip_dle_d;

  logic is_dle, is_etx, is_pid;

  assign is_dle = (i_rx_byte == DLE);
  assign is_etx = (i_rx_byte == ETX);
  assign is_pid = (i_rx_byte == PACKET_ID);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      skip_dle_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_dle_q <= skip_dle_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    skip_dle_d = skip_dle_q;
    if (i_rx_dv) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_dle) state_d = ST_GET_ID;
        end
        ST_GET_ID: begin
          if (is_dle || is_etx) begin
            state_d = ST_IDLE;
          end else if (is_pid) begin
            state_d = ST_DATA;
          end else begin
            state_d    = ST_SKIP;
            skip_dle_d = 1'b0;
          end
        end
        ST_DATA: begin
          if (is_dle) state_d = ST_DATA_DLE;
        end
        ST_DATA_DLE: begin
          unique case (1'b1)
            is_dle: state_d = ST_DATA;
            is_etx: state_d = ST_IDLE;
            is_pid: state_d = ST_DATA;
            default: begin
              state_d    = ST_SKIP;
              skip_dle_d = 1'b0;
            end
          endcase
        end
        ST_SKIP: begin
          if (!skip_dle_q) begin
            if (is_dle) skip_dle_d = 1'b1;
          end else begin
            skip_dle_d = 1'b0;
            unique case (1'b1)
              is_etx: state_d = ST_IDLE;
              is_dle: state_d = ST_SKIP;
              is_pid: state_d = ST_DATA;
              default: state_d = ST_SKIP;
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_byte = i_rx_byte;
  assign o_id   = i_rx_byte;

  always_comb begin
    o_byte_dv = 1'b0;
    o_sop     = 1'b0;
    o_eop     = 1'b0;
    o_abort   = 1'b0;
    if (i_rx_dv) begin
      unique case (state_q)
        ST_GET_ID: begin
          o_sop = !is_dle && !is_etx;
        end
        ST_DATA: begin
          o_byte_dv = !is_dle;
        end
        ST_DATA_DLE: begin
          unique case (1'b1)
            is_dle: o_byte_dv = 1'b1;
            is_etx: o_eop     = 1'b1;
            default: begin
              o_abort = 1'b1;
              o_sop   = 1'b1;
            end
          endcase
        end
        ST_SKIP: begin
          o_sop = skip_dle_q && !is_dle && !is_etx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/thunder_tsip_parser.sv
// thunder_tsip_parser: extracts UTC time from TSIP primary timing packets.
// Ports: i_clk, i_rst (sync, active high), i_rx_dv/i_rx_byte (UART bytes);
//   o_thunder_packet_dv strobe plus held year/month/day/hour/min/sec
//   outputs, o_err_cnt saturating count of rejected matching-ID packets.
// Build option: define THUNDER_RANGE_CHECK_EN to reject implausible fields.
module thunder_tsip_parser
  import thunder_tsip_pkg::*;
#(
  parameter logic [7:0] PACKET_ID  = 8'h8F,
  parameter logic [7:0] PACKET_SUB = 8'hAB
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_thunder_packet_dv,
  output logic [15:0] o_thunder_year,
  output logic [7:0]  o_thunder_month,
  output logic [7:0]  o_thunder_day,
  output logic [7:0]  o_thunder_hour,
  output logic [7:0]  o_thunder_minutes,
  output logic [7:0]  o_thunder_seconds,
  output logic [7:0]  o_err_cnt
);

  logic       df_byte_dv, df_sop, df_eop, df_abort;
  logic [7:0] df_byte, df_id;

  tsip_deframer #(
    .PACKET_ID (PACKET_ID)
  ) u_deframer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rx_dv   (i_rx_dv),
    .i_rx_byte (i_rx_byte),
    .o_byte_dv (df_byte_dv),
    .o_byte    (df_byte),
    .o_sop     (df_sop),
    .o_id      (df_id),
    .o_eop     (df_eop),
    .o_abort   (df_abort)
  );

  logic [4:0]  idx_q, idx_d;
  // Shadow fields fill as bytes arrive; outputs only see them on a good ETX.
  logic [7:0]  sub_q, sub_d;
  logic [7:0]  sh_sec_q, sh_sec_d;
  logic [7:0]  sh_min_q, sh_min_d;
  logic [7:0]  sh_hr_q, sh_hr_d;
  logic [7:0]  sh_day_q, sh_day_d;
  logic [7:0]  sh_mon_q, sh_mon_d;
  logic [15:0] sh_yr_q, sh_yr_d;

  logic [7:0]  sec_q, sec_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  hr_q, hr_d;
  logic [7:0]  day_q, day_d;
  logic [7:0]  mon_q, mon_d;
  logic [15:0] yr_q, yr_d;
  logic        dv_q, dv_d;
  logic [7:0]  err_q, err_d;

  logic range_ok, pkt_ok, bump_err;

`ifdef THUNDER_RANGE_CHECK_EN
  assign range_ok = fields_in_range(sh_sec_q, sh_min_q, sh_hr_q,
                                    sh_day_q, sh_mon_q, sh_yr_q);
`else
  assign range_ok = 1'b1;
`endif

  assign pkt_ok = (sub_q == PACKET_SUB) && (idx_q == PKT_LEN) && range_ok;

  // An abort only occurs inside an accepted-ID packet, so it always counts.
  assign bump_err = (df_eop && !pkt_ok) || df_abort;

  always_comb begin
    idx_d    = idx_q;
    sub_d    = sub_q;
    sh_sec_d = sh_sec_q;
    sh_min_d = sh_min_q;
    sh_hr_d  = sh_hr_q;
    sh_day_d = sh_day_q;
    sh_mon_d = sh_mon_q;
    sh_yr_d  = sh_yr_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    day_d    = day_q;
    mon_d    = mon_q;
    yr_d     = yr_q;
    dv_d     = 1'b0;
    err_d    = err_q;

    if (df_sop && (df_id == PACKET_ID)) idx_d = 5'd0;

    if (df_byte_dv) begin
      case (idx_q)
        IDX_SUB:   sub_d         = df_byte;
        IDX_SEC:   sh_sec_d      = df_byte;
        IDX_MIN:   sh_min_d      = df_byte;
        IDX_HOUR:  sh_hr_d       = df_byte;
        IDX_DAY:   sh_day_d      = df_byte;
        IDX_MON:   sh_mon_d      = df_byte;
        IDX_YR_HI: sh_yr_d[15:8] = df_byte;
        IDX_YR_LO: sh_yr_d[7:0]  = df_byte;
        default: ;
      endcase
      if (idx_q != IDX_MAX) idx_d = idx_q + 5'd1;
    end

    if (df_eop && pkt_ok) begin
      sec_d = sh_sec_q;
      min_d = sh_min_q;
      hr_d  = sh_hr_q;
      day_d = sh_day_q;
      mon_d = sh_mon_q;
      yr_d  = sh_yr_q;
      dv_d  = 1'b1;
    end

    if (bump_err && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_q    <= '0;
      sub_q    <= '0;
      sh_sec_q <= '0;
      sh_min_q <= '0;
      sh_hr_q  <= '0;
      sh_day_q <= '0;
      sh_mon_q <= '0;
      sh_yr_q  <= '0;
      sec_q    <= '0;
      min_q    <= '0;
      hr_q     <= '0;
      day_q    <= '0;
      mon_q    <= '0;
      yr_q     <= '0;
      dv_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      sub_q    <= sub_d;
      sh_sec_q <= sh_sec_d;
      sh_min_q <= sh_min_d;
      sh_hr_q  <= sh_hr_d;
      sh_day_q <= sh_day_d;
      sh_mon_q <= sh_mon_d;
      sh_yr_q  <= sh_yr_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hr_q     <= hr_d;
      day_q    <= day_d;
      mon_q    <= mon_d;
      yr_q     <= yr_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
    end
  end

  assign o_thunder_packet_dv = dv_q;
  assign o_thunder_year      = yr_q;
  assign o_thunder_month     = mon_q;
  assign o_thunder_day       = day_q;
  assign o_thunder_hour      = hr_q;
  assign o_thunder_minutes   = min_q;
  assign o_thunder_seconds   = sec_q;
  assign o_err_cnt           = err_q;

endmodule

// File: tb/tb_thunder_tsip_parser.sv
// Directed bench for thunder_tsip_parser: packet table plus hand-written
// abort / foreign-ID / mid-packet reset sequences.
module tb_thunder_tsip_parser;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rx_dv;
  logic [7:0]  i_rx_byte;
  logic        o_dv;
  logic [15:0] o_yr;
  logic [7:0]  o_mon, o_day, o_hr, o_min, o_sec, o_err;

  thunder_tsip_parser dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_rx_dv             (i_rx_dv),
    .i_rx_byte           (i_rx_byte),
    .o_thunder_packet_dv (o_dv),
    .o_thunder_year      (o_yr),
    .o_thunder_month     (o_mon),
    .o_thunder_day       (o_day),
    .o_thunder_hour      (o_hr),
    .o_thunder_minutes   (o_min),
    .o_thunder_seconds   (o_sec),
    .o_err_cnt           (o_err)
  );

  always #5 i_clk = ~i_clk;

  int compared = 0;
  int failed   = 0;
  int strobes  = 0;
  logic prev_dv = 1'b0;

  typedef struct {
    logic [7:0]  sub;
    int          n;
    logic [7:0]  sec, mn, hr, day, mon;
    logic [15:0] yr;
    logic        exp_dv;
    logic [55:0] exp_t;
    logic [7:0]  exp_err;
  } vec_t;

  function automatic logic [55:0] tp(
    input logic [7:0] sec, mn, hr, day, mon, input logic [15:0] yr);
    return {yr, mon, day, hr, mn, sec};
  endfunction

  function automatic vec_t mk(
    input logic [7:0] sub, input int n,
    input logic [7:0] sec, mn, hr, day, mon, input logic [15:0] yr,
    input logic exp_dv, input logic [55:0] exp_t, input logic [7:0] exp_err);
    vec_t v;
    v.sub = sub; v.n = n; v.sec = sec; v.mn = mn; v.hr = hr;
    v.day = day; v.mon = mon; v.yr = yr;
    v.exp_dv = exp_dv; v.exp_t = exp_t; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic logic [7:0] body_byte(input int i, input vec_t v);
    case (i)
      0:  return v.sub;
      10: return v.sec;
      11: return v.mn;
      12: return v.hr;
      13: return v.day;
      14: return v.mon;
      15: return v.yr[15:8];
      16: return v.yr[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    @(negedge i_clk);
    i_rx_dv   = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    if (b == 8'h10) send(8'h10);
    send(b);
  endtask

  task automatic send_body(input vec_t v, input int from, input int to);
    for (int i = from; i < to; i++) send_data(body_byte(i, v));
  endtask

  task automatic send_pkt(input logic [7:0] id, input vec_t v);
    send(8'h10);
    send(id);
    send_body(v, 0, v.n);
    send(8'h10);
    send(8'h03);
  endtask

  function automatic logic [55:0] outs();
    return {o_yr, o_mon, o_day, o_hr, o_min, o_sec};
  endfunction

  always @(negedge i_clk) begin
    if (o_dv === 1'b1) begin
      strobes++;
      compared++;
      if (prev_dv === 1'b1) begin
        failed++;
        $display("FAIL back_to_back_strobe: got 1 want 0");
      end
    end
    prev_dv = o_dv;
  end

  localparam logic [55:0] T0 = {16'h07E8, 8'd6, 8'd15, 8'd12, 8'd30, 8'd5};
  localparam logic [55:0] T1 = {16'h07E8, 8'd6, 8'd15, 8'd12, 8'd30, 8'd16};
  localparam logic [55:0] T5 = {16'h07E8, 8'd13, 8'd15, 8'd12, 8'd30, 8'd16};
  localparam logic [55:0] T6 = {16'h07E8, 8'd6, 8'd15, 8'd12, 8'd30, 8'd60};
  localparam logic [55:0] T7 = {16'h07E8, 8'd6, 8'd15, 8'd12, 8'd30, 8'd7};

  vec_t vecs[7];
  vec_t v;
  logic [7:0] err_exp;
  int exp_strobes;

  initial begin
    vecs[0] = mk(8'hAB, 17, 8'd5, 8'd30, 8'd12, 8'd15, 8'd6, 16'h07E8,
                 1'b1, T0, 8'd0);
    vecs[1] = mk(8'hAB, 17, 8'h10, 8'd30, 8'd12, 8'd15, 8'd6, 16'h07E8,
                 1'b1, T1, 8'd0);
    vecs[2] = mk(8'hAB, 16, 8'd5, 8'd30, 8'd12, 8'd15, 8'd6, 16'h07E8,
                 1'b0, T1, 8'd1);
    vecs[3] = mk(8'hAB, 18, 8'd5, 8'd30, 8'd12, 8'd15, 8'd6, 16'h07E8,
                 1'b0, T1, 8'd2);
    vecs[4] = mk(8'hAC, 17, 8'd5, 8'd30, 8'd12, 8'd15, 8'd6, 16'h07E8,
                 1'b0, T1, 8'd3);
`ifdef THUNDER_RANGE_CHECK_EN
    vecs[5] = mk(8'hAB, 17, 8'd16, 8'd30, 8'd12, 8'd15, 8'd13, 16'h07E8,
                 1'b0, T1, 8'd4);
    vecs[6] = mk(8'hAB, 17, 8'd60, 8'd30, 8'd12, 8'd15, 8'd6, 16'h07E8,
                 1'b1, T6, 8'd4);
    exp_strobes = 5;
`else
    vecs[5] = mk(8'hAB, 17, 8'd16, 8'd30, 8'd12, 8'd15, 8'd13, 16'h07E8,
                 1'b1, T5, 8'd3);
    vecs[6] = mk(8'hAB, 17, 8'd60, 8'd30, 8'd12, 8'd15, 8'd6, 16'h07E8,
                 1'b1, T6, 8'd3);
    exp_strobes = 6;
`endif

    i_rst = 1'b1;
    i_rx_dv = 1'b0;
    i_rx_byte = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("reset_dv", {63'd0, o_dv}, 64'd0);
    chk("reset_time", {8'd0, outs()}, 64'd0);
    chk("reset_err", {56'd0, o_err}, 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    for (int k = 0; k < 7; k++) begin
      send_pkt(8'h8F, vecs[k]);
      chk($sformatf("vec%0d_dv", k), {63'd0, o_dv}, {63'd0, vecs[k].exp_dv});
      chk($sformatf("vec%0d_time", k), {8'd0, outs()}, {8'd0, vecs[k].exp_t});
      chk($sformatf("vec%0d_err", k), {56'd0, o_err},
          {56'd0, vecs[k].exp_err});
      @(negedge i_clk);
    end
    err_exp = vecs[6].exp_err;

    // Foreign ID with embedded 8F AB and a stuffed DLE pair.
    send(8'h10); send(8'h47); send(8'h8F); send(8'hAB);
    send(8'h10); send(8'h10); send(8'h8F); send(8'hAB);
    send(8'h10); send(8'h03);
    chk("foreign_dv", {63'd0, o_dv}, 64'd0);
    chk("foreign_time", {8'd0, outs()}, {8'd0, T6});
    chk("foreign_err", {56'd0, o_err}, {56'd0, err_exp});

    // Accepted packet cut by DLE + new 8F ID; new packet completes.
    v = mk(8'hAB, 17, 8'd7, 8'd30, 8'd12, 8'd15, 8'd6, 16'h07E8,
           1'b1, T7, 8'd0);
    send(8'h10); send(8'h8F); send(8'hAB); send(8'h00);
    send(8'h10); send(8'h8F);
    send_body(v, 0, 17);
    send(8'h10); send(8'h03);
    chk("abort_dv", {63'd0, o_dv}, 64'd1);
    chk("abort_time", {8'd0, outs()}, {8'd0, T7});
    chk("abort_err", {56'd0, o_err}, {56'd0, err_exp + 8'd1});
    @(negedge i_clk);

    // Reset after 8 bytes of a valid packet; byte during reset is dropped.
    v = vecs[0];
    send(8'h10); send(8'h8F);
    send_body(v, 0, 6);
    i_rst = 1'b1; i_rx_dv = 1'b1; i_rx_byte = 8'h10;
    @(negedge i_clk);
    i_rst = 1'b0; i_rx_dv = 1'b0;
    chk("midrst_time", {8'd0, outs()}, 64'd0);
    chk("midrst_err", {56'd0, o_err}, 64'd0);
    send_body(v, 6, 17);
    send(8'h10); send(8'h03);
    chk("remainder_dv", {63'd0, o_dv}, 64'd0);
    chk("remainder_time", {8'd0, outs()}, 64'd0);
    @(negedge i_clk);
    send_pkt(8'h8F, v);
    chk("postrst_dv", {63'd0, o_dv}, 64'd1);
    chk("postrst_time", {8'd0, outs()}, {8'd0, T0});
    chk("postrst_err", {56'd0, o_err}, 64'd0);
    repeat (3) @(negedge i_clk);

    chk("strobe_total", 64'(strobes), 64'(exp_strobes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, failed);
    $finish;
  end

endmodule

// File: doc/thunder_tsip_parser.md
THUNDER_TSIP_PARSER -- requirements
Module: thunder_tsip_parser

Interface
REQ-001 Parameter PACKET_ID, default 'h8F: TSIP packet ID accepted.
REQ-002 Parameter PACKET_SUB, default 'hAB: required subcode, the first data byte.
REQ-003 i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_rx_dv  input  1  one-cycle strobe; i_rx_byte valid.
REQ-006 i_rx_byte  input  8  received UART byte.
REQ-007 o_thunder_packet_dv  output  1  one-cycle strobe; time fields updated.
REQ-008 o_thunder_year  output  16  UTC year.
REQ-009 o_thunder_month, o_thunder_day, o_thunder_hour, o_thunder_minutes, o_thunder_seconds  output  8 each  UTC fields.
REQ-010 o_err_cnt  output  8  saturating count of rejected PACKET_ID/PACKET_SUB packets.

Function
REQ-011 Framing: DLE='h10, ETX='h03; packet = DLE, ID, destuffed data, DLE ETX; DLE,DLE inside data = one data byte 'h10.
REQ-012 FSM states: IDLE, GET_ID, DATA, DATA_DLE, SKIP; the FSM advances only on cycles with i_rx_dv=1.
REQ-013 IDLE: DLE -> GET_ID; other bytes are ignored.
REQ-014 GET_ID: byte==PACKET_ID -> DATA with data index 0; DLE or ETX -> IDLE; other ID -> SKIP.
REQ-015 DATA: DLE -> DATA_DLE; other byte is stored at the current index, then the index increments.
REQ-016 DATA_DLE: DLE -> store 'h10, return to DATA; ETX -> end of packet, evaluate, go to IDLE; other byte -> previous packet dropped (counted as error), byte taken as new ID, evaluated as in GET_ID.
REQ-017 SKIP: tracks DLE-stuffing like DATA/DATA_DLE without storing; DLE ETX -> IDLE; DLE X (X not DLE/ETX) -> X is the new ID.
REQ-018 Data index is 5-bit and saturates at 31; it does not wrap.
REQ-019 Byte map by destuffed data index: 0 subcode; 10 seconds; 11 minutes; 12 hours; 13 day; 14 month; 15 year[15:8]; 16 year[7:0]; indices 1-9 are discarded.
REQ-020 The packet is valid iff subcode==PACKET_SUB, final index==17, and the range check (REQ-031) passes when compiled in.
REQ-021 Valid packet: outputs are loaded from shadow registers and o_thunder_packet_dv=1 in the cycle after the ETX byte's i_rx_dv cycle; latency is exactly 1 clock.
REQ-022 Invalid packet with ID==PACKET_ID: outputs are unchanged, no strobe, o_err_cnt increments and holds at 255.
REQ-023 Packets with a different ID never change outputs or o_err_cnt.
REQ-024 Time outputs hold their last valid values between strobes; shadow registers alone absorb partial packets.
REQ-025 o_thunder_packet_dv is never asserted on two consecutive cycles.

Reset
REQ-026 When i_rst=1 at an edge: FSM -> IDLE, index=0, and all outputs and o_err_cnt = 0.
REQ-027 Reset mid-packet: the partial packet is discarded; the next packet is only accepted after a fresh DLE,ID.
REQ-028 Reset has priority over an i_rx_dv byte in the same cycle; that byte is dropped.

Configuration
REQ-029 The macro THUNDER_RANGE_CHECK_EN selects the field range check.
REQ-030 Without the macro: no field-range checking.
REQ-031 With the macro: the packet is invalid (REQ-022) if seconds>60, minutes>59, hours>23, day==0 or >31, month==0 or >12, or year<2000.

Structure
REQ-032 Package thunder_tsip_pkg holds: DLE/ETX constants, FSM state typedef, byte-index constants for each field, and the expected length 17.
REQ-033 Sub-module tsip_deframer performs destuffing and framing, emitting a byte strobe plus ID and sop/eop/abort flags; the parent handles field capture and validation.

Verification
REQ-034 Valid 0x8F-AB packet (sec 5, min 30, hr 12, day 15, mon 6, year 'h07E8) -> one strobe 1 clock after ETX; outputs 5/30/12/15/6/2024; o_err_cnt=0.
REQ-035 Same packet with seconds='h10 stuffed as DLE,DLE -> o_thunder_seconds=16 and one strobe.
REQ-036 0x8F-AB packet with 16 data bytes, then one with 18 data bytes -> no strobe; outputs hold previous values; o_err_cnt=2.
REQ-037 Packet 0x8F-AC, then 0x47 packet with an embedded 'h8F,'hAB -> no strobe; o_err_cnt=1 (0x8F-AC only).
REQ-038 i_rst asserted after byte 8 of a valid packet, then the remainder sent, then a full valid packet -> outputs 0 after reset; only the final packet strobes.
REQ-039 THUNDER_RANGE_CHECK_EN defined, month=13 -> no strobe, o_err_cnt+1; undefined -> strobe, month=13.
